demux_12_deser: RTL
===================

DEMUX_12_DESER -- requirements
Module: demux_12_deser

Interface
REQ-001 The block SHALL have the ports below, clock and reset first (name  direction  width  meaning).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 D  input  1  serial data bit.
REQ-005 S  input  1  channel select: 0 routes D to channel 0, 1 to channel 1.
REQ-006 D_valid  input  1  D and S are valid this cycle.
REQ-007 D_ready  output  1  block accepts D this cycle; transfer = D_valid & D_ready.
REQ-008 Q0, Q1  output  8 each  assembled word per channel.
REQ-009 Q0_valid, Q1_valid  output  1 each  word on Qx is valid.
REQ-010 Q0_ready, Q1_ready  input  1 each  consumer takes Qx; pop = Qx_valid & Qx_ready.
REQ-011 perr  output  2  per-channel parity error flag, bit x qualifies Qx.

Function
REQ-012 Per channel: 8-bit shift register SRx, bit counter CNTx, output register Qx, flag Qx_valid; channels fully independent.
REQ-013 On transfer with S=x, D SHALL shift into SRx MSB (SRx <= {D, SRx[7:1]}), LSB-first framing: first bit received ends in Qx[0].
REQ-014 CNTx SHALL count accepted data bits 0..7 and wrap to 0 on frame completion; the unselected channel's SR and CNT SHALL hold.
REQ-015 On the final data bit of a frame (CNTx=7, parity disabled), Qx SHALL load {D, SRx[7:1]} and Qx_valid SHALL be 1 the next cycle: latency 1 clk from last bit to Qx_valid.
REQ-016 Qx_valid SHALL clear on pop; simultaneous pop and new frame load SHALL leave Qx_valid=1 with the new word (load wins).
REQ-017 Qx and perr[x] SHALL hold stable while Qx_valid=1 and no pop.
REQ-018 D_ready SHALL be 0 only when the selected channel is on its final frame bit and Qs_valid=1 and Qs_ready=0 (combinational on S, CNT, Qs_valid, Qs_ready); otherwise 1.
REQ-019 A non-final bit SHALL be accepted even while Qx_valid=1 (SRx is separate from Qx).
REQ-020 S MAY change every accepted bit; interleaved frames SHALL assemble correctly per channel.
REQ-021 With D_valid=0, no state other than pop-driven Qx_valid clearing SHALL change.

Reset
REQ-022 rst=1 SHALL asynchronously force SR0, SR1, CNT0, CNT1, Q0, Q1 to 0, Q0_valid, Q1_valid to 0, perr to 2'b00.
REQ-023 Reset mid-frame SHALL discard partial frames; first bit after rst deassert is bit 0 of a new frame.
REQ-024 D_ready SHALL be 1 during and after reset (all channels empty).

Configuration
REQ-025 Macro DEMUX_PARITY_EN SHALL control parity checking.
REQ-026 Defined: frame = 8 data bits + 1 even-parity bit (CNTx 0..8); load occurs on the parity bit; perr[x] registered with Qx, 1 when XOR of 8 data bits and parity bit is 1; "final bit" in REQ-018 means CNTx=8.
REQ-027 Not defined: frame = 8 bits, perr SHALL be constant 2'b00; port list unchanged.

Verification
REQ-028 Reset then 8 bits on S=0, values 1,0,1,0,0,1,0,1 (first to last), Q0_ready=0 -> next cycle Q0=8'hA5, Q0_valid=1, Q1_valid=0.
REQ-029 Alternate S each bit, channel 0 sends 8'h3C, channel 1 sends 8'hC3 LSB-first -> Q0=8'h3C and Q1=8'hC3, each valid 1 clk after its last bit.
REQ-030 Q0 holds 8'h11 unread (Q0_ready=0), send 7 bits of 8'h22 -> all accepted; 8th bit -> D_ready=0 until Q0_ready=1; same cycle pop+load -> Q0=8'h22, Q0_valid stays 1.
REQ-031 Assert rst after 4 bits of channel 1 -> Q1_valid=0, CNT cleared; then full 8'hFF frame -> Q1=8'hFF.
REQ-032 DEMUX_PARITY_EN defined: send 8'h07 with parity 1 -> perr[0]=0; send 8'h07 with parity 0 -> perr[0]=1 with Q0_valid.
REQ-033 D_valid low for 5 cycles between bits 3 and 4 of 8'h5A -> Q0=8'h5A, no extra bits captured.

Source files
------------

// File: rtl/demux_12_deser.sv
// demux_12_deser: two-channel serial-to-parallel demux with valid/ready word outputs.
// Define DEMUX_PARITY_EN for 8 data bits + 1 even-parity bit per frame with perr reporting.
module demux_12_deser (
  input  logic       clk,
  input  logic       rst,
  input  logic       D,
  input  logic       S,
  input  logic       D_valid,
  output logic       D_ready,
  output logic [7:0] Q0,
  output logic [7:0] Q1,
  output logic       Q0_valid,
  output logic       Q1_valid,
  input  logic       Q0_ready,
  input  logic       Q1_ready,
  output logic [1:0] perr
);
`ifdef DEMUX_PARITY_EN
  localparam logic [3:0] LAST = 4'd8;
  logic [1:0] r_perr;
`else
  localparam logic [3:0] LAST = 4'd7;
`endif
  logic [7:0] r_sr [2];
  logic [3:0] r_cnt [2];
  logic [7:0] r_q [2];
  logic [1:0] r_qv;
  logic [1:0] w_qrdy;
  logic [1:0] w_acc;
  logic [1:0] w_ld;
  logic [7:0] w_word [2];
  always_comb begin
    w_qrdy = {Q1_ready, Q0_ready};
    D_ready = !((r_cnt[S] == LAST) && r_qv[S] && !w_qrdy[S]);
    w_acc = 2'b00;
    w_ld = 2'b00;
    for (int c = 0; c < 2; c++) begin
      w_acc[c] = D_valid && D_ready && (S == c[0]);
      w_ld[c] = w_acc[c] && (r_cnt[c] == LAST);
`ifdef DEMUX_PARITY_EN
      w_word[c] = r_sr[c];
`else
      w_word[c] = {D, r_sr[c][7:1]};
`endif
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        r_sr[c] <= 8'h00;
        r_cnt[c] <= 4'd0;
        r_q[c] <= 8'h00;
      end
      r_qv <= 2'b00;
`ifdef DEMUX_PARITY_EN
      r_perr <= 2'b00;
`endif
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (w_acc[c]) begin
          r_sr[c] <= {D, r_sr[c][7:1]};
          r_cnt[c] <= w_ld[c] ? 4'd0 : r_cnt[c] + 4'd1;
        end
        if (w_ld[c]) begin
          r_q[c] <= w_word[c];
`ifdef DEMUX_PARITY_EN
          r_perr[c] <= ^{r_sr[c], D};
`endif
        end
        r_qv[c] <= w_ld[c] || (r_qv[c] && !w_qrdy[c]);
      end
    end
  end
  assign Q0 = r_q[0];
  assign Q1 = r_q[1];
  assign Q0_valid = r_qv[0];
  assign Q1_valid = r_qv[1];
`ifdef DEMUX_PARITY_EN
  assign perr = r_perr;
`else
  assign perr = 2'b00;
`endif
endmodule
